reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Shares the register file's single destination (rd) write port among NUM_REQ write-back requesters (index 0 = ALU, index 1 = LSU).
- Uses a valid/ready handshake, round-robin arbitration and a one-entry registered write stage that drives rd_web/rd_addr/rd_data.
- Sits between the execute/memory write-back sources and the register file's rd port; preserves write order per acceptance.

Parameters:
- NUM_REQ, 2, number of write-back requesters (≥2).
- ADDR_WIDTH, 5, register address width (REG_ADDR_WIDTH).
- XLEN, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous release.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester accept; handshake when valid & ready at a rising edge.
- req_addr  input  NUM_REQ*ADDR_WIDTH  destination register; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*XLEN  write data; requester i uses slice [i*XLEN +: XLEN].
- wb_hold  input  1  write-back freeze (debug/stall); 1 = suppress register file write.
- rd_web  output  1  register file write enable, 1 = write at the next rising edge.
- rd_addr  output  ADDR_WIDTH  register file write address.
- rd_data  output  XLEN  register file write data.
- wb_busy  output  1  write stage occupied (slot_valid).

Behaviour:
- Write stage (slot): holds slot_valid, slot_addr and slot_data.
  - rd_web = slot_valid & ~wb_hold.
  - rd_addr = slot_addr; rd_data = slot_data.
- Slot accept condition: can_accept = ~slot_valid | rd_web, so the slot drains and refills in the same cycle.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first valid wins.
  - req_ready[i] = can_accept & (i == winner). At most one ready bit is high per cycle.
  - Ready may depend on valid.
  - Requesters hold valid/addr/data stable until ready; deasserting valid before the handshake is illegal.
- On handshake with requester i:
  - Load slot_addr and slot_data.
  - rr_ptr ← (i+1) mod NUM_REQ.
  - slot_valid ← (addr ≠ 0). An x0 write is accepted and dropped, never driven to the register file.
- Slot empties when rd_web = 1 and no new handshake occurs that cycle.
- Latency: handshake at edge k → rd_web = 1 in the cycle after k (if wb_hold = 0) → register file written at edge k+1. Throughput is 1 write/cycle.
- wb_hold = 1:
  - rd_web = 0; slot retained unchanged.
  - If slot_valid = 1, all req_ready = 0. If slot_valid = 0, one request may still be accepted into the slot.
- No valid requests: rr_ptr unchanged; slot drains normally.
- Ordering: writes reach the register file in handshake order. Two writes to the same register keep the later value.
- Reset (rst = 0, any time, including mid-transfer):
  - slot_valid = 0, slot_addr = 0, slot_data = 0, rr_ptr = 0.
  - rd_web = 0, rd_addr = 0, rd_data = 0, wb_busy = 0, req_ready = all 0.
  - A pending slot is discarded.

Optional Feature:
- Macro: REG_WB_ARBITER_BYPASS_EN.
- Defined: adds the following ports.
  - rs1_addr, rs2_addr (ADDR_WIDTH, input).
  - rf_rs1_data, rf_rs2_data (XLEN, input; register file read data).
  - rs1_data, rs2_data (XLEN, output).
- Bypass rule: rsN_data = slot_data when slot_valid & (rsN_addr == slot_addr) & (rsN_addr ≠ 0); otherwise rsN_data = rf_rsN_data. The bypass is combinational and also applies while wb_hold = 1.
- Undefined: these ports do not exist; the block has no read-path logic.

Test Plan:
- Single write: req_valid = 01, addr = 5, data = 0xDEADBEEF → ready[0] = 1 same cycle; next cycle rd_web = 1, rd_addr = 5, rd_data = 0xDEADBEEF; following cycle rd_web = 0.
- Round-robin: both requesters continuously valid (addr 1, 2) for 4 cycles from reset → grants 0, 1, 0, 1; rd_addr sequence 1, 2, 1, 2 with rd_web high 4 consecutive cycles.
- x0 drop: req_valid = 10, addr = 0, data = 0x1234 → ready[1] = 1; rd_web stays 0; rr_ptr advances (next simultaneous request grants 0).
- Hold: slot holds addr 7; wb_hold = 1 for 3 cycles with req 0 valid → rd_web = 0, req_ready = 00, wb_busy = 1 throughout. Release → rd_web = 1 (addr 7), then req 0 is accepted the same cycle.
- Reset mid-operation: slot valid (addr 9), assert rst low between edges → rd_web, wb_busy, req_ready drop to 0 immediately. After release, no write to register 9 occurs.
- Bypass (macro defined): slot holds addr 3 = 0xA5A5A5A5, rs1_addr = 3, rf_rs1_data = 0 → rs1_data = 0xA5A5A5A5. With rs2_addr = 0 → rs2_data = rf_rs2_data.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbiter sharing the register file rd write port
// among NUM_REQ write-back sources (0 = ALU, 1 = LSU), with a one-entry
// registered write stage feeding rd_web/rd_addr/rd_data.
// Optional read bypass from the write stage: define REG_WB_ARBITER_BYPASS_EN.
module reg_wb_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned XLEN       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]       req_data,
    input  logic                          wb_hold,
`ifdef REG_WB_ARBITER_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0]         rs1_addr,
    input  logic [ADDR_WIDTH-1:0]         rs2_addr,
    input  logic [XLEN-1:0]               rf_rs1_data,
    input  logic [XLEN-1:0]               rf_rs2_data,
    output logic [XLEN-1:0]               rs1_data,
    output logic [XLEN-1:0]               rs2_data,
`endif
    output logic                          rd_web,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [XLEN-1:0]               rd_data,
    output logic                          wb_busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                  r_slot_valid;
    logic [ADDR_WIDTH-1:0] r_slot_addr;
    logic [XLEN-1:0]       r_slot_data;
    logic [PTR_W-1:0]      r_rr_ptr;

    logic                  w_can_accept;
    logic                  w_any_valid;
    logic [PTR_W-1:0]      w_winner;
    logic [PTR_W-1:0]      w_idx;
    logic [PTR_W-1:0]      w_next_ptr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_hs;

    // Slot drives the register file; hold masks the write but keeps the slot
    assign rd_web       = r_slot_valid & ~wb_hold;
    assign rd_addr      = r_slot_addr;
    assign rd_data      = r_slot_data;
    assign wb_busy      = r_slot_valid;
    assign w_can_accept = ~r_slot_valid | rd_web;

    // Round-robin search from r_rr_ptr; lowest offset wins, so scan downwards
    always_comb begin
        w_any_valid = 1'b0;
        w_winner    = '0;
        w_idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_any_valid = 1'b1;
                w_winner    = w_idx;
            end
        end
    end

    // Winner payload mux, grant vector and pointer advance
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == w_winner) begin
                w_sel_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data   = req_data[i*XLEN +: XLEN];
                req_ready[i] = rst & w_can_accept & w_any_valid;
            end
        end
        w_next_ptr = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
    end

    assign w_hs = rst & w_can_accept & w_any_valid;

    // Write stage and arbitration pointer; x0 writes are accepted then dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_valid <= 1'b0;
            r_slot_addr  <= '0;
            r_slot_data  <= '0;
            r_rr_ptr     <= '0;
        end else if (w_hs) begin
            r_slot_valid <= (w_sel_addr != '0);
            r_slot_addr  <= w_sel_addr;
            r_slot_data  <= w_sel_data;
            r_rr_ptr     <= w_next_ptr;
        end else if (rd_web) begin
            r_slot_valid <= 1'b0;
        end
    end

`ifdef REG_WB_ARBITER_BYPASS_EN
    // Forward the pending write to readers; x0 never forwards
    always_comb begin
        rs1_data = rf_rs1_data;
        rs2_data = rf_rs2_data;
        if (r_slot_valid && (rs1_addr == r_slot_addr) && (rs1_addr != '0))
            rs1_data = r_slot_data;
        if (r_slot_valid && (rs2_addr == r_slot_addr) && (rs2_addr != '0))
            rs2_data = r_slot_data;
    end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: vector table plus hand sequences for
// mid-cycle reset, same-register ordering and the optional bypass.
module tb_reg_wb_arbiter;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned XLEN       = 32;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*XLEN-1:0]       req_data;
    logic                          wb_hold;
    logic                          rd_web;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic [XLEN-1:0]               rd_data;
    logic                          wb_busy;
`ifdef REG_WB_ARBITER_BYPASS_EN
    logic [ADDR_WIDTH-1:0]         rs1_addr, rs2_addr;
    logic [XLEN-1:0]               rf_rs1_data, rf_rs2_data, rs1_data, rs2_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    reg_wb_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .wb_hold    (wb_hold),
`ifdef REG_WB_ARBITER_BYPASS_EN
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rf_rs1_data(rf_rs1_data),
        .rf_rs2_data(rf_rs2_data),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
`endif
        .rd_web     (rd_web),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wb_busy    (wb_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        hold;
        logic [1:0]  e_ready;
        logic        e_web;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [1:0] v,
                                input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic h, input logic [1:0] er, input logic ew,
                                input logic [4:0] ea, input logic [31:0] ed,
                                input logic eb);
        vec_t t;
        t.rst = r; t.valid = v; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
        t.hold = h; t.e_ready = er; t.e_web = ew; t.e_addr = ea; t.e_data = ed;
        t.e_busy = eb;
        return t;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1, input logic h);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        wb_hold   = h;
    endtask

    initial begin
        rst = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
`ifdef REG_WB_ARBITER_BYPASS_EN
        rs1_addr = '0; rs2_addr = '0; rf_rs1_data = '0; rf_rs2_data = '0;
`endif

        // reset state and single write
        vecs.push_back(mk(1, 2'b00, 0, 32'h0, 0, 32'h0, 0, 2'b00, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 2'b01, 5, 32'hDEADBEEF, 0, 32'h0, 0, 2'b01, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 2'b00, 5, 32'hDEADBEEF, 0, 32'h0, 0, 2'b00, 1, 5, 32'hDEADBEEF, 1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0, 0, 32'h0, 0, 2'b00, 0, 5, 32'hDEADBEEF, 0));
        // reset again, then round-robin with both requesters valid
        vecs.push_back(mk(0, 2'b11, 1, 32'h11, 2, 32'h22, 0, 2'b00, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h11, 2, 32'h22, 0, 2'b01, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h11, 2, 32'h22, 0, 2'b10, 1, 1, 32'h11, 1));
        vecs.push_back(mk(1, 2'b11, 1, 32'h11, 2, 32'h22, 0, 2'b01, 1, 2, 32'h22, 1));
        vecs.push_back(mk(1, 2'b11, 1, 32'h11, 2, 32'h22, 0, 2'b10, 1, 1, 32'h11, 1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0, 0, 32'h0, 0, 2'b00, 1, 2, 32'h22, 1));
        // x0 write from requester 1 is dropped but advances the pointer
        vecs.push_back(mk(1, 2'b01, 4, 32'h44, 0, 32'h0, 0, 2'b01, 0, 2, 32'h22, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0, 0, 32'h1234, 0, 2'b10, 1, 4, 32'h44, 1));
        vecs.push_back(mk(1, 2'b11, 6, 32'h66, 8, 32'h88, 0, 2'b01, 0, 0, 32'h1234, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0, 0, 32'h0, 0, 2'b00, 1, 6, 32'h66, 1));
        // hold with an occupied slot, then release
        vecs.push_back(mk(1, 2'b01, 7, 32'h77, 0, 32'h0, 0, 2'b01, 0, 6, 32'h66, 0));
        vecs.push_back(mk(1, 2'b01, 10, 32'hAA, 0, 32'h0, 1, 2'b00, 0, 7, 32'h77, 1));
        vecs.push_back(mk(1, 2'b01, 10, 32'hAA, 0, 32'h0, 1, 2'b00, 0, 7, 32'h77, 1));
        vecs.push_back(mk(1, 2'b01, 10, 32'hAA, 0, 32'h0, 1, 2'b00, 0, 7, 32'h77, 1));
        vecs.push_back(mk(1, 2'b01, 10, 32'hAA, 0, 32'h0, 0, 2'b01, 1, 7, 32'h77, 1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0, 0, 32'h0, 0, 2'b00, 1, 10, 32'hAA, 1));
        // hold with an empty slot still accepts one request
        vecs.push_back(mk(1, 2'b10, 0, 32'h0, 3, 32'h33, 1, 2'b10, 0, 10, 32'hAA, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0, 0, 32'h0, 1, 2'b00, 0, 3, 32'h33, 1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0, 0, 32'h0, 0, 2'b00, 1, 3, 32'h33, 1));

        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            drive(vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1, vecs[i].hold);
            #1;
            check("req_ready", i, 32'(req_ready), 32'(vecs[i].e_ready));
            check("rd_web",    i, 32'(rd_web),    32'(vecs[i].e_web));
            check("rd_addr",   i, 32'(rd_addr),   32'(vecs[i].e_addr));
            check("rd_data",   i, rd_data,        vecs[i].e_data);
            check("wb_busy",   i, 32'(wb_busy),   32'(vecs[i].e_busy));
        end

        // reset between edges while the slot holds a write to x9
        @(negedge clk);
        drive(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b0);
        #1 check("mid_rst_accept", 100, 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 check("mid_rst_loaded_addr", 101, 32'(rd_addr), 32'd9);
        check("mid_rst_loaded_web", 101, 32'(rd_web), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_web",   102, 32'(rd_web),    32'h0);
        check("mid_rst_busy",  102, 32'(wb_busy),   32'h0);
        check("mid_rst_ready", 102, 32'(req_ready), 32'h0);
        check("mid_rst_addr",  102, 32'(rd_addr),   32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1 check("post_rst_web", 103 + c, 32'(rd_web), 32'h0);
            @(negedge clk);
        end

        // two writes to the same register keep grant order
        drive(2'b11, 5'd5, 32'h1, 5'd5, 32'h2, 1'b0);
        #1 check("order_ready0", 110, 32'(req_ready), 32'h1);
        @(negedge clk);
        #1 check("order_ready1", 111, 32'(req_ready), 32'h2);
        check("order_first", 111, rd_data, 32'h1);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        #1 check("order_second", 112, rd_data, 32'h2);
        check("order_second_web", 112, 32'(rd_web), 32'h1);
        @(negedge clk);

`ifdef REG_WB_ARBITER_BYPASS_EN
        // bypass from the held slot
        drive(2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
        rs1_addr = 5'd3; rf_rs1_data = 32'h0;
        rs2_addr = 5'd0; rf_rs2_data = 32'h5A5A0F0F;
        #1;
        check("bypass_rs1", 120, rs1_data, 32'hA5A5A5A5);
        check("bypass_rs2_x0", 120, rs2_data, 32'h5A5A0F0F);
        rs2_addr = 5'd4;
        #1 check("bypass_rs2_miss", 121, rs2_data, 32'h5A5A0F0F);
        @(negedge clk);
        wb_hold = 1'b0;
        @(negedge clk);
        #1 check("bypass_drained", 122, rs1_data, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
